// File: rtl/drive_pkg.sv
// Shared types, constants and helpers for the drivetrain command arbiter.
// Nibble layout: dir = {FWD_A, FWD_B, BWD_A, BWD_B}, duty = {Duty_SelA, Duty_SelB}.
package drive_pkg;

    localparam int CNT_W = 27;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACK_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_DEAD     = 2'd3;

    localparam logic [3:0] DIR_COAST  = 4'b0000;
    localparam logic [3:0] DIR_FWD    = 4'b1100;
    localparam logic [3:0] DIR_SPIN_R = 4'b1001;
    localparam logic [3:0] DIR_SPIN_L = 4'b0110;
    localparam logic [3:0] DIR_BWD    = 4'b0011;

    typedef struct packed {
        logic [3:0] dir;
        logic [3:0] duty;
    } drive_cmd_t;

    // A wheel with both FWD and BWD set would short the bridge leg; coast instead.
    function automatic drive_cmd_t coast_if_illegal(input drive_cmd_t c);
        drive_cmd_t r;
        r = c;
        if ((c.dir[3] && c.dir[1]) || (c.dir[2] && c.dir[0])) begin
            r = '0;
        end
        return r;
    endfunction

    function automatic logic [1:0] lowest_req(input logic [2:0] req);
        logic [1:0] idx;
        if (req[0]) begin
            idx = 2'd0;
        end else if (req[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd2;
        end
        return idx;
    endfunction

endpackage

// File: rtl/drive_arbiter_if.sv
// Controller-side bundle of the drive arbiter: requests, Done, commands, grant and muxed drive.
// master = direction controllers / PWM stage, slave = arbiter.
interface drive_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  done;
    logic [11:0] cmd_dir;
    logic [11:0] cmd_duty;
    logic        pause;
    logic [2:0]  grant;
    logic        FWD_A;
    logic        FWD_B;
    logic        BWD_A;
    logic        BWD_B;
    logic [1:0]  Duty_SelA;
    logic [1:0]  Duty_SelB;
    logic        busy;
    logic        ack_err;

    modport master (
        output req, done, cmd_dir, cmd_duty, pause,
        input  grant, FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB, busy, ack_err
    );

    modport slave (
        input  req, done, cmd_dir, cmd_duty, pause,
        output grant, FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB, busy, ack_err
    );
endinterface

// File: rtl/drive_deadtime_timer.sv
// Shared cycle counter: cleared on load, counts up while not held, stops at 'last'.
// expire is combinational on the registered count; hold freezes the count.
module drive_deadtime_timer
    import drive_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             hold,
    input  logic [CNT_W-1:0] last,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (!hold && !expire) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/drive_arbiter.sv
// Grants the drivetrain command path to one of three controllers, coasting through a dead-time on every change.
// All outputs registered (1 cycle); requesters wait for grant, pause forces coast and freezes the FSM.
module drive_arbiter
    import drive_pkg::*;
#(
    parameter int unsigned DEAD_CYC    = 1_000_000,
    parameter int unsigned ACK_TIMEOUT = 10_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    drive_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    logic [1:0]       state, state_nxt;
    logic [1:0]       owner, owner_nxt;
    logic [2:0]       grant, grant_nxt;
    drive_cmd_t       drv, drv_nxt;
    drive_cmd_t       own;
    logic             ack_err, ack_err_nxt;
    logic             busy;
    logic             pause_q;
    logic             expire;
    logic             load;
    logic             dir_chg;
    logic             resume;
    logic [CNT_W-1:0] last;

    assign own     = {bus.cmd_dir[{owner, 2'b00} +: 4], bus.cmd_duty[{owner, 2'b00} +: 4]};
    assign dir_chg = (own.dir != drv.dir) && (|own.dir) && (|drv.dir);
    assign resume  = pause_q && (|own.dir);
    assign last    = (state == ST_DEAD) ? DEAD_LAST : ACK_LAST;
    assign load    = (state_nxt != state);

    drive_deadtime_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .hold   (bus.pause),
        .last   (last),
        .expire (expire)
    );

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        grant_nxt   = grant;
        drv_nxt     = '0;
        ack_err_nxt = 1'b0;
        if (!bus.pause) begin
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        owner_nxt = lowest_req(bus.req);
                        grant_nxt = 3'b001 << owner_nxt;
                        state_nxt = ST_ACK_WAIT;
                    end
                end
                ST_ACK_WAIT: begin
                    if (!bus.done[owner]) begin
                        state_nxt = ST_RUN;
                    end else if (expire) begin
                        grant_nxt   = '0;
                        ack_err_nxt = 1'b1;
                        state_nxt   = ST_DEAD;
                    end
                end
                ST_RUN: begin
                    // Preempt outranks done, which outranks a direction change or pause resume.
                    if ((bus.req[0] && owner != 2'd0) || bus.done[owner]) begin
                        grant_nxt = '0;
                        state_nxt = ST_DEAD;
                    end else if (dir_chg || resume) begin
                        state_nxt = ST_DEAD;
                    end else begin
                        drv_nxt = coast_if_illegal(own);
                    end
                end
                default: begin
                    if (expire) begin
                        if (|grant) begin
                            state_nxt = ST_RUN;
                            drv_nxt   = coast_if_illegal(own);
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            owner   <= '0;
            grant   <= '0;
            drv     <= '0;
            ack_err <= 1'b0;
            busy    <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            grant   <= grant_nxt;
            drv     <= drv_nxt;
            ack_err <= ack_err_nxt;
            busy    <= (state_nxt != ST_IDLE);
            pause_q <= bus.pause;
        end
    end

    assign bus.grant                                  = grant;
    assign {bus.FWD_A, bus.FWD_B, bus.BWD_A, bus.BWD_B} = drv.dir;
    assign {bus.Duty_SelA, bus.Duty_SelB}             = drv.duty;
    assign bus.busy                                   = busy;
    assign bus.ack_err                                = ack_err;

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed scenarios plus randomized traffic, every cycle compared against a countdown-based reference model.
module tb_drive_arbiter;
    import drive_pkg::*;

    localparam int DC = 6;
    localparam int AT = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    drive_arbiter_if bus();

    drive_arbiter #(.DEAD_CYC(DC), .ACK_TIMEOUT(AT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] dut_dir, dut_duty;
    assign dut_dir  = {bus.FWD_A, bus.FWD_B, bus.BWD_A, bus.BWD_B};
    assign dut_duty = {bus.Duty_SelA, bus.Duty_SelB};

    logic [3:0] dir_tab [7] = '{DIR_COAST, DIR_FWD, DIR_SPIN_R, DIR_SPIN_L, DIR_BWD, 4'b1111, 4'b1010};

    // Reference model: phase 0 idle, 1 awaiting Done, 2 driving, 3 coasting; m_left counts down remaining cycles.
    int         m_phase, m_owner, m_left;
    bit         m_hold, m_err, m_prevp;
    bit   [3:0] m_dir, m_duty;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_left = 0;
        m_hold = 0; m_err = 0; m_prevp = 0;
        m_dir = 0; m_duty = 0;
    endtask

    task automatic model_drive(input bit [3:0] nib, input bit [3:0] dty);
        bit wheel_a_short, wheel_b_short;
        wheel_a_short = nib[3] && nib[1];
        wheel_b_short = nib[2] && nib[0];
        if (!wheel_a_short && !wheel_b_short) begin
            m_dir = nib; m_duty = dty;
        end
    endtask

    task automatic model_step();
        bit [3:0] nib, dty, prev;
        bit fell;
        nib  = bus.cmd_dir[m_owner*4 +: 4];
        dty  = bus.cmd_duty[m_owner*4 +: 4];
        fell = m_prevp && !bus.pause;
        m_prevp = bus.pause;
        m_err = 0;
        prev = m_dir;
        m_dir = 0; m_duty = 0;
        if (bus.pause) return;
        case (m_phase)
            0: if (bus.req != 0) begin
                m_owner = bus.req[0] ? 0 : (bus.req[1] ? 1 : 2);
                m_hold = 1; m_phase = 1; m_left = AT;
            end
            1: if (!bus.done[m_owner]) m_phase = 2;
               else if (m_left == 1) begin m_hold = 0; m_err = 1; m_phase = 3; m_left = DC; end
               else m_left--;
            2: if ((bus.req[0] && m_owner != 0) || bus.done[m_owner]) begin
                m_hold = 0; m_phase = 3; m_left = DC;
            end else if ((nib != 0 && prev != 0 && nib != prev) || (fell && nib != 0)) begin
                m_phase = 3; m_left = DC;
            end else model_drive(nib, dty);
            default: if (m_left == 1) begin
                if (m_hold) begin m_phase = 2; model_drive(nib, dty); end
                else m_phase = 0;
            end else m_left--;
        endcase
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [12:0] exp, got;
        @(posedge clk);
        model_step();
        #1;
        exp = {(m_hold ? 3'(3'b001 << m_owner) : 3'b000), m_dir, m_duty, (m_phase != 0), m_err};
        got = {bus.grant, dut_dir, dut_duty, bus.busy, bus.ack_err};
        chk($sformatf("outputs@%0t", $time), {3'b0, got}, {3'b0, exp});
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 3; i++) begin
            if (m_hold && m_owner == i) begin
                if (bus.done[i] && $urandom_range(0, 5) == 0) bus.done[i] = 1'b0;
                else if (!bus.done[i] && $urandom_range(0, 30) == 0) bus.done[i] = 1'b1;
            end else if (!bus.done[i] && $urandom_range(0, 3) == 0) begin
                bus.done[i] = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) bus.req[i] = ~bus.req[i];
            if ($urandom_range(0, 9) == 0) bus.cmd_dir[4*i +: 4] = dir_tab[$urandom_range(0, 6)];
            if ($urandom_range(0, 19) == 0) bus.cmd_duty[4*i +: 4] = 4'($urandom);
        end
        if (bus.pause) begin
            if ($urandom_range(0, 3) == 0) bus.pause = 1'b0;
        end else if ($urandom_range(0, 49) == 0) begin
            bus.pause = 1'b1;
        end
    endtask

    initial begin
        bus.req = 3'b000; bus.done = 3'b111; bus.pause = 1'b0;
        bus.cmd_dir = '0; bus.cmd_duty = '0;
        model_reset();
        #2;
        chk("reset", {3'b0, bus.grant, dut_dir, dut_duty, bus.busy, bus.ack_err}, 16'h0);
        #10 rst_n = 1'b1;

        // T1 single request
        bus.req = 3'b010;
        bus.cmd_dir[7:4] = DIR_FWD; bus.cmd_duty[7:4] = 4'b1001;
        tick(); chk("t1_grant", {13'b0, bus.grant}, 16'h2);
        tick(); tick();
        bus.done[1] = 1'b0;
        tick(); chk("t1_run_entry", {12'b0, dut_dir}, 16'h0);
        tick(); chk("t1_track", {8'b0, dut_dir, dut_duty}, 16'h00C9);
        bus.req = 3'b000;
        tick();
        bus.done[1] = 1'b1;
        tick(); chk("t1_release", {9'b0, bus.grant, dut_dir}, 16'h0);
        repeat (DC - 1) tick();
        chk("t1_dead_busy", {15'b0, bus.busy}, 16'h1);
        tick(); chk("t1_idle", {15'b0, bus.busy}, 16'h0);

        // T2 priority
        bus.req = 3'b110;
        tick(); chk("t2_pick", {13'b0, bus.grant}, 16'h2);
        bus.done[1] = 1'b0;
        tick();
        bus.done[1] = 1'b1; bus.req = 3'b100;
        tick(); chk("t2_release", {13'b0, bus.grant}, 16'h0);
        repeat (DC) tick();
        tick(); chk("t2_next", {13'b0, bus.grant}, 16'h4);

        // T3 preempt
        bus.done[2] = 1'b0;
        bus.cmd_dir[11:8] = DIR_FWD; bus.cmd_duty[11:8] = 4'b0110;
        tick(); tick(); chk("t3_drive", {12'b0, dut_dir}, 16'h000C);
        bus.req = 3'b001;
        tick(); chk("t3_preempt", {9'b0, bus.grant, dut_dir}, 16'h0);
        bus.done[2] = 1'b1;
        repeat (DC) tick();
        tick(); chk("t3_regrant", {13'b0, bus.grant}, 16'h1);

        // T4 reversal
        bus.done[0] = 1'b0;
        bus.cmd_dir[3:0] = DIR_FWD; bus.cmd_duty[3:0] = 4'b1111;
        tick(); tick(); chk("t4_fwd", {12'b0, dut_dir}, 16'h000C);
        bus.cmd_dir[3:0] = DIR_BWD;
        tick(); chk("t4_dead", {9'b0, bus.grant, dut_dir}, 16'h0010);
        for (int k = 0; k < DC - 1; k++) begin
            tick(); chk("t4_coast", {9'b0, bus.grant, dut_dir}, 16'h0010);
        end
        tick(); chk("t4_rev", {9'b0, bus.grant, dut_dir}, 16'h0013);
        bus.done[0] = 1'b1; bus.req = 3'b000;
        tick();
        repeat (DC) tick();

        // T5 ACK timeout
        bus.req = 3'b010;
        tick(); chk("t5_grant", {13'b0, bus.grant}, 16'h2);
        bus.req = 3'b000;
        repeat (AT - 1) tick();
        chk("t5_noerr", {15'b0, bus.ack_err}, 16'h0);
        tick(); chk("t5_err", {12'b0, bus.grant, bus.ack_err}, 16'h1);
        tick(); chk("t5_pulse", {15'b0, bus.ack_err}, 16'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            tick();
        end

        // T6 async reset mid-RUN
        bus.req = 3'b000; bus.done = 3'b111; bus.pause = 1'b0;
        repeat (DC + AT + 4) tick();
        bus.req = 3'b100;
        tick();
        bus.done[2] = 1'b0; bus.cmd_dir[11:8] = DIR_SPIN_R;
        tick(); tick(); tick();
        chk("t6_pre", {9'b0, bus.grant, dut_dir}, 16'h0049);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_reset", {3'b0, bus.grant, dut_dir, dut_duty, bus.busy, bus.ack_err}, 16'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rand_inputs();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
